// File: rtl/fifo_umbrales.sv
// fifo_umbrales: per-lane circular-buffer FIFO with registered empty/full
// status and almost-empty/almost-full flags compared against the live
// bajo/alto thresholds published by the flow-control machine.
// Optional feature macro: FIFO_STICKY_ERR_EN (error_out latches until reset
// instead of pulsing for one cycle).

module fifo_umbrales #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            bajo,
   input  logic [7:0]            alto,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic                  error_out
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
   logic                  validOut_q, validOut_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  almostEmpty_q, almostEmpty_d;
   logic                  almostFull_q, almostFull_d;
   logic                  error_q, error_d;

   logic popOk;
   logic pushOk;
   logic overflow;
   logic underflow;

   // Accept/reject decisions, next pointers/count, and the status flags
   // evaluated on the post-edge count with the thresholds present now.
   always_comb begin
      popOk     = pop && !empty_q;
      pushOk    = push && (!full_q || popOk);
      overflow  = push && full_q && !popOk;
      underflow = pop && empty_q;

      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      dataOut_d  = dataOut_q;
      validOut_d = 1'b0;

      if (pushOk) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (popOk) begin
         rdPtr_d    = rdPtr_q + 1'b1;
         dataOut_d  = mem_q[rdPtr_q];
         validOut_d = 1'b1;
      end

      case ({pushOk, popOk})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      empty_d       = (count_d == '0);
      full_d        = (count_d == (ADDR_WIDTH+1)'(DEPTH));
      almostEmpty_d = (8'(count_d) <= bajo);
      almostFull_d  = (8'(count_d) >= alto);

`ifdef FIFO_STICKY_ERR_EN
      error_d = error_q | overflow | underflow;
`else
      error_d = overflow | underflow;
`endif
   end

   // Storage array; deliberately not reset, stale words are unreachable
   // once the pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem_q[wrPtr_q] <= data_in;
      end
   end

   // Pointer, count, read-data and status registers with async clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         count_q       <= '0;
         dataOut_q     <= '0;
         validOut_q    <= 1'b0;
         empty_q       <= 1'b1;
         full_q        <= 1'b0;
         almostEmpty_q <= 1'b1;
         almostFull_q  <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         count_q       <= count_d;
         dataOut_q     <= dataOut_d;
         validOut_q    <= validOut_d;
         empty_q       <= empty_d;
         full_q        <= full_d;
         almostEmpty_q <= almostEmpty_d;
         almostFull_q  <= almostFull_d;
         error_q       <= error_d;
      end
   end

   assign data_out     = dataOut_q;
   assign valid_out    = validOut_q;
   assign count        = count_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = almostEmpty_q;
   assign almost_full  = almostFull_q;
   assign error_out    = error_q;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Testbench for fifo_umbrales: directed scenarios followed by randomized
// traffic, checked against a queue-based reference model and a read-data
// scoreboard drained by an independent monitor.

module tb_fifo_umbrales;

   localparam int DW    = 10;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    bajo;
   logic [7:0]    alto;
   logic          push;
   logic          pop;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          almost_empty;
   logic          almost_full;
   logic          error_out;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] modelQ[$];
   logic [DW-1:0] expQ[$];
   bit            expValid;
   bit            expErr;
   bit            expAE;
   bit            expAF;
   logic [DW-1:0] lastData;

   fifo_umbrales #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .bajo         (bajo),
      .alto         (alto),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .error_out    (error_out)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compares every status output against the reference model.
   task automatic checkStatus();
      checkOutput("count", 32'(count), 32'(modelQ.size()));
      checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0));
      checkOutput("full", 32'(full), 32'(modelQ.size() == DEPTH));
      checkOutput("almostEmpty", 32'(almost_empty), 32'(expAE));
      checkOutput("almostFull", 32'(almost_full), 32'(expAF));
      checkOutput("validOut", 32'(valid_out), 32'(expValid));
      checkOutput("errorOut", 32'(error_out), 32'(expErr));
      if (!expValid) begin
         checkOutput("dataHold", 32'(data_out), 32'(lastData));
      end
   endtask

   // Expected values while reset is asserted or just released.
   task automatic checkResetValues(input string tag);
      checkOutput({tag, "Count"}, 32'(count), 32'd0);
      checkOutput({tag, "Empty"}, 32'(empty), 32'd1);
      checkOutput({tag, "Full"}, 32'(full), 32'd0);
      checkOutput({tag, "AlmostEmpty"}, 32'(almost_empty), 32'd1);
      checkOutput({tag, "AlmostFull"}, 32'(almost_full), 32'd0);
      checkOutput({tag, "ValidOut"}, 32'(valid_out), 32'd0);
      checkOutput({tag, "ErrorOut"}, 32'(error_out), 32'd0);
      checkOutput({tag, "DataOut"}, 32'(data_out), 32'd0);
   endtask

   // One clock of stimulus; the model is advanced at the edge from the
   // FIFO rules (queue occupancy), and outputs are checked at the negedge.
   task automatic applyStimulus(input bit p, input bit q, input logic [DW-1:0] d);
      int cnt;
      bit popAcc;
      bit pushAcc;
      bit err;
      push    = p;
      pop     = q;
      data_in = d;
      @(posedge clk);
      cnt     = modelQ.size();
      popAcc  = q && (cnt > 0);
      pushAcc = p && ((cnt < DEPTH) || popAcc);
      err     = (p && (cnt == DEPTH) && !popAcc) || (q && (cnt == 0));
      expValid = popAcc;
      if (popAcc) begin
         lastData = modelQ.pop_front();
         expQ.push_back(lastData);
      end
      if (pushAcc) begin
         modelQ.push_back(d);
      end
`ifdef FIFO_STICKY_ERR_EN
      expErr = expErr | err;
`else
      expErr = err;
`endif
      expAE = (modelQ.size() <= int'(bajo));
      expAF = (modelQ.size() >= int'(alto));
      @(negedge clk);
      checkStatus();
   endtask

   // Asynchronous reset pulse, checked immediately, while held and after release.
   task automatic doReset(input int cycles);
      #2;
      reset = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      #1;
      checkResetValues("rstAsync");
      repeat (cycles) @(negedge clk);
      checkResetValues("rstHeld");
      modelQ.delete();
      expQ.delete();
      expValid = 1'b0;
      expErr   = 1'b0;
      expAE    = 1'b1;
      expAF    = 1'b0;
      lastData = '0;
      reset    = 1'b1;
      #1;
      checkResetValues("rstRelease");
   endtask

   // Monitor: every presented word is matched against the scoreboard head.
   always @(negedge clk) begin : monitor
      logic [DW-1:0] e;
      if (reset === 1'b1 && valid_out === 1'b1) begin
         if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpectedValid: got data %0d expected no word at %0t", data_out, $time);
         end else begin
            e = expQ.pop_front();
            checkOutput("dataOut", 32'(data_out), 32'(e));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios, then randomized traffic.
   initial begin
      reset    = 1'b1;
      push     = 1'b0;
      pop      = 1'b0;
      data_in  = '0;
      bajo     = 8'd2;
      alto     = 8'd6;
      expValid = 1'b0;
      expErr   = 1'b0;
      lastData = '0;
      doReset(2);

      // Fill to full, then drain in order.
      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, DW'(i));
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, '0);
      applyStimulus(1'b0, 1'b0, '0);

      // Wrap-around with pointer rollover.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, DW'($urandom));
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, '0);
      applyStimulus(1'b1, 1'b0, 10'h3FF);
      applyStimulus(1'b1, 1'b0, 10'h155);
      applyStimulus(1'b1, 1'b0, 10'h2AA);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, '0);
      applyStimulus(1'b0, 1'b0, '0);

      // Full: simultaneous push+pop, then overflow, then drain.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, DW'($urandom));
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, DW'($urandom));
      applyStimulus(1'b1, 1'b0, 10'h0AB);
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, '0);

      // Empty: simultaneous push+pop accepts only the push.
      applyStimulus(1'b1, 1'b1, 10'h123);
      applyStimulus(1'b0, 1'b1, '0);
      applyStimulus(1'b0, 1'b0, '0);

      // Threshold change at count 4, then reset mid-burst.
      doReset(2);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, DW'($urandom));
      alto = 8'd4;
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, DW'($urandom));
      applyStimulus(1'b1, 1'b1, DW'($urandom));
      doReset(2);

      // Randomized traffic with moving thresholds and occasional resets.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            bajo = 8'($urandom_range(0, 10));
            alto = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(9, 255)) : 8'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 120) == 0) begin
            doReset(1);
         end else begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), DW'($urandom));
         end
      end

      // Drain remaining words so the scoreboard must empty.
      for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 1'b1, '0);
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("scoreboardDrain", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
